// File: rtl/pc_bus_pkg.sv
// Shared PC bus definitions: controller states, bus cycle codes
// and the wait-state selection used by the bus and DMA logic.
package pc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T2,
    ST_WAIT,
    ST_DMA_GRANT,
    ST_DMA_REL
  } ws_state_t;

  typedef enum logic [1:0] {
    CYC_MEM     = 2'b00,
    CYC_IO      = 2'b01,
    CYC_INTA    = 2'b10,
    CYC_PASSIVE = 2'b11
  } cycle_t;

  function automatic logic [3:0] ws_count(
    input logic [1:0] ct,
    input logic [3:0] mem_ws,
    input logic [3:0] io_ws
  );
    return (ct == CYC_MEM) ? mem_ws : io_ws;
  endfunction

endpackage

// File: rtl/ws_counter.sv
// 4-bit wait-state down counter: load, decrement on enable,
// zero flag. Decrement saturates at zero.
module ws_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/wait_state_ctrl.sv
// PC bus wait-state generator with DMA hold arbitration.
// Advances only on processor-clock ticks; all outputs registered.
module wait_state_ctrl
  import pc_bus_pkg::*;
#(
  parameter int unsigned MEM_WS = 0,
  parameter int unsigned IO_WS  = 1
) (
  input  logic       fpga_clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       bus_start,
  input  logic [1:0] cycle_type,
  input  logic       dma_req,
  output logic       rdy1,
  output logic       aen1,
  output logic       dma_ack,
  output logic       busy
);

  ws_state_t  state_q, state_d;
  logic       rdy1_q, rdy1_d;
  logic       aen1_q, aen1_d;
  logic       ack_q, ack_d;
  logic       busy_q, busy_d;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic       start_ok;
  logic [3:0] load_val;

  assign start_ok = bus_start &&
                    (cycle_type != CYC_PASSIVE);
  assign load_val = ws_count(cycle_type,
                             4'(MEM_WS),
                             4'(IO_WS));

  ws_counter u_cnt (
    .clk_i      (fpga_clk),
    .rst_ni     (reset_n),
    .load_i     (cnt_load),
    .load_val_i (load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    rdy1_d   = rdy1_q;
    aen1_d   = aen1_q;
    ack_d    = ack_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          // processor wins a same-tick DMA request
          if (start_ok) begin
            cnt_load = 1'b1;
            state_d  = ST_T2;
          end else if (dma_req) begin
            aen1_d  = 1'b1;
            state_d = ST_DMA_GRANT;
          end
        end
        ST_T2: begin
          if (cnt_zero) begin
            rdy1_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            rdy1_d  = 1'b0;
            cnt_dec = 1'b1;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_zero) begin
            rdy1_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_DMA_GRANT: begin
          if (dma_req) begin
            ack_d = 1'b1;
          end else begin
            ack_d   = 1'b0;
            state_d = ST_DMA_REL;
          end
        end
        ST_DMA_REL: begin
          aen1_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rdy1_q  <= 1'b1;
      aen1_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy1_q  <= rdy1_d;
      aen1_q  <= aen1_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign rdy1    = rdy1_q;
  assign aen1    = aen1_q;
  assign dma_ack = ack_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_wait_state_ctrl.sv
// Self-checking bench for wait_state_ctrl: directed scenarios
// plus randomized traffic against an interval-based model.
module tb_wait_state_ctrl;

  localparam int MEM_WS = 0;
  localparam int IO_WS  = 3;

  logic       fpga_clk;
  logic       reset_n;
  logic       tick;
  logic       bus_start;
  logic [1:0] cycle_type;
  logic       dma_req;
  logic       rdy1, aen1, dma_ack, busy;
  logic [3:0] o;

  int checks = 0;
  int errors = 0;

  assign o = {rdy1, aen1, dma_ack, busy};

  wait_state_ctrl #(
    .MEM_WS (MEM_WS),
    .IO_WS  (IO_WS)
  ) dut (
    .fpga_clk   (fpga_clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .bus_start  (bus_start),
    .cycle_type (cycle_type),
    .dma_req    (dma_req),
    .rdy1       (rdy1),
    .aen1       (aen1),
    .dma_ack    (dma_ack),
    .busy       (busy)
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  // one non-tick clock with junk inputs, then one tick clock
  task automatic tk(
    input logic       bs,
    input logic [1:0] ct,
    input logic       dr
  );
    @(negedge fpga_clk);
    tick       = 1'b0;
    bus_start  = 1'($urandom);
    cycle_type = 2'($urandom);
    dma_req    = 1'($urandom);
    @(posedge fpga_clk);
    @(negedge fpga_clk);
    tick       = 1'b1;
    bus_start  = bs;
    cycle_type = ct;
    dma_req    = dr;
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge fpga_clk);
    #1;
    checks++;
    if (o !== 4'b1000) begin
      errors++;
      $display("FAIL reset_hold got %b exp %b", o, 4'b1000);
    end
    @(negedge fpga_clk);
    reset_n   = 1'b1;
    bus_start = 1'b1;
    dma_req   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge fpga_clk);
      #1;
      checks++;
      if (o !== 4'b1000) begin
        errors++;
        $display("FAIL reset_notick%0d got %b exp %b",
                 i, o, 4'b1000);
      end
    end
    tk(1'b0, 2'd0, 1'b0);
    checks++;
    if (o !== 4'b1000) begin
      errors++;
      $display("FAIL reset_idle_tick got %b exp %b", o, 4'b1000);
    end
  endtask

  task automatic test_mem_cycle();
    logic [4:0] bs_v;
    logic [3:0] exp [0:4];
    bs_v = 5'b01101;
    exp  = '{4'b1001, 4'b1000, 4'b1001, 4'b1000, 4'b1000};
    for (int i = 0; i < 5; i++) begin
      tk(bs_v[i], 2'd0, 1'b0);
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL mem_cycle t%0d got %b exp %b",
                 i, o, exp[i]);
      end
    end
  endtask

  task automatic test_io_cycle();
    logic [3:0] exp [0:5];
    exp = '{4'b1001, 4'b0001, 4'b0001,
            4'b0001, 4'b1000, 4'b1000};
    for (int c = 1; c <= 2; c++) begin
      for (int i = 0; i < 6; i++) begin
        tk(i == 0, 2'(c), 1'b0);
        checks++;
        if (o !== exp[i]) begin
          errors++;
          $display("FAIL io_cycle type%0d t%0d got %b exp %b",
                   c, i, o, exp[i]);
        end
      end
    end
  endtask

  task automatic test_dma();
    logic [7:0] dr_v;
    logic [3:0] exp [0:7];
    dr_v = 8'b00011111;
    exp  = '{4'b1101, 4'b1111, 4'b1111, 4'b1111,
             4'b1111, 4'b1101, 4'b1000, 4'b1000};
    for (int i = 0; i < 8; i++) begin
      tk(1'b0, 2'd0, dr_v[i]);
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL dma t%0d got %b exp %b", i, o, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] bs_v, dr_v;
    logic [3:0] exp [0:8];
    bs_v = 9'b000000001;
    dr_v = 9'b001111111;
    exp  = '{4'b1001, 4'b0001, 4'b0001, 4'b0001, 4'b1000,
             4'b1101, 4'b1111, 4'b1101, 4'b1000};
    for (int i = 0; i < 9; i++) begin
      tk(bs_v[i], 2'd1, dr_v[i]);
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL priority t%0d got %b exp %b",
                 i, o, exp[i]);
      end
    end
  endtask

  task automatic test_ignored();
    logic [6:0] bs_v, dr_v;
    logic [1:0] ct_v [0:6];
    logic [3:0] exp  [0:6];
    bs_v = 7'b0111101;
    dr_v = 7'b0001110;
    ct_v = '{2'd3, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    exp  = '{4'b1000, 4'b1101, 4'b1111, 4'b1111,
             4'b1101, 4'b1000, 4'b1000};
    for (int i = 0; i < 7; i++) begin
      tk(bs_v[i], ct_v[i], dr_v[i]);
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL ignored t%0d got %b exp %b",
                 i, o, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    tk(1'b1, 2'd1, 1'b0);
    tk(1'b0, 2'd0, 1'b0);
    checks++;
    if (o !== 4'b0001) begin
      errors++;
      $display("FAIL rst_wait_pre got %b exp %b", o, 4'b0001);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (o !== 4'b1000) begin
      errors++;
      $display("FAIL rst_wait_async got %b exp %b", o, 4'b1000);
    end
    @(negedge fpga_clk);
    tick       = 1'b0;
    bus_start  = 1'b1;
    cycle_type = 2'd1;
    dma_req    = 1'b1;
    reset_n    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge fpga_clk);
      #1;
      checks++;
      if (o !== 4'b1000) begin
        errors++;
        $display("FAIL rst_wait_notick%0d got %b exp %b",
                 i, o, 4'b1000);
      end
    end
    tk(1'b0, 2'd0, 1'b1);
    checks++;
    if (o !== 4'b1101) begin
      errors++;
      $display("FAIL rst_wait_first got %b exp %b", o, 4'b1101);
    end
    tk(1'b0, 2'd0, 1'b0);
    tk(1'b0, 2'd0, 1'b0);
    checks++;
    if (o !== 4'b1000) begin
      errors++;
      $display("FAIL rst_wait_done got %b exp %b", o, 4'b1000);
    end
  endtask

  // Model: each activity is a span of tick indices after which
  // busy / rdy1-low / aen1 hold; free_at is the next tick that
  // may accept new work.
  task automatic test_random();
    int n, w, big;
    int free_at, busy_from, busy_end;
    int lo_first, lo_last, aen_from, aen_until;
    bit granted, ack;
    logic       bs, dr;
    logic [1:0] ct;
    logic [3:0] exp;
    big = 1 << 30;
    n = 0; free_at = 0; granted = 0; ack = 0;
    busy_from = 1; busy_end = 0;
    lo_first = 1; lo_last = 0;
    aen_from = 1; aen_until = 0;
    dr = 1'b0;
    // start from IDLE with the controller settled
    tk(1'b0, 2'd0, 1'b0);
    tk(1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 400; k++) begin
      bs = ($urandom_range(2) == 0);
      ct = 2'($urandom);
      if ($urandom_range(3) == 0) dr = ~dr;
      tk(bs, ct, dr);
      if (granted) begin
        if (dr) begin
          ack = 1;
        end else begin
          ack = 0; granted = 0;
          aen_until = n; busy_end = n;
          free_at = n + 2;
        end
      end else if (n >= free_at) begin
        if (bs && ct != 2'd3) begin
          w = (ct == 2'd0) ? MEM_WS : IO_WS;
          busy_from = n; busy_end = n + w;
          lo_first = n + 1; lo_last = n + w;
          free_at = n + w + 2;
        end else if (dr) begin
          granted = 1; ack = 0;
          aen_from = n; aen_until = big;
          busy_from = n; busy_end = big;
        end
      end
      exp = {!(n >= lo_first && n <= lo_last),
             (n >= aen_from && n <= aen_until),
             ack,
             (n >= busy_from && n <= busy_end)};
      n++;
      checks++;
      if (o !== exp) begin
        errors++;
        $display("FAIL random k%0d got %b exp %b", k, o, exp);
      end
      if (k % 97 == 96) begin
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (o !== 4'b1000) begin
          errors++;
          $display("FAIL random_rst k%0d got %b exp %b",
                   k, o, 4'b1000);
        end
        @(negedge fpga_clk);
        tick    = 1'b0;
        reset_n = 1'b1;
        n = 0; free_at = 0; granted = 0; ack = 0;
        busy_from = 1; busy_end = 0;
        lo_first = 1; lo_last = 0;
        aen_from = 1; aen_until = 0;
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    tick       = 1'b0;
    bus_start  = 1'b0;
    cycle_type = 2'd0;
    dma_req    = 1'b0;
    test_reset();
    test_mem_cycle();
    test_io_cycle();
    test_dma();
    test_back_to_back();
    test_ignored();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
